// File: rtl/segre_history_buffer.sv
// In-order history buffer: allocate at tail, complete by id, retire DONE entries from head,
// roll back youngest-first when an excepting entry reaches head. Optional stats: SEGRE_HB_STATS_EN.
module segre_history_buffer #(
    parameter int HB_DEPTH = 8,
    parameter int N_CMPL   = 4,
    parameter int RET_W    = 2,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    localparam int HB_PTR  = $clog2(HB_DEPTH),
    localparam int RC_W    = $clog2(RET_W + 1)
) (
    input  logic                     clk_i,
    input  logic                     rsn_i,
    input  logic                     alloc_valid_i,
    input  logic                     alloc_store_i,
    input  logic [REG_W-1:0]         alloc_dest_reg_i,
    input  logic [DATA_W-1:0]        alloc_value_i,
    input  logic [ADDR_W-1:0]        alloc_pc_i,
    output logic [HB_PTR-1:0]        alloc_id_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [HB_PTR:0]          count_o,
    input  logic [N_CMPL-1:0]        cmpl_valid_i,
    input  logic [N_CMPL*HB_PTR-1:0] cmpl_id_i,
    input  logic                     exc_valid_i,
    input  logic [HB_PTR-1:0]        exc_id_i,
    output logic                     store_perm_o,
    output logic [RC_W-1:0]          retire_cnt_o,
    output logic                     recovering_o,
    output logic                     rb_valid_o,
    output logic [REG_W-1:0]         rb_dest_reg_o,
    output logic [DATA_W-1:0]        rb_value_o,
    output logic [ADDR_W-1:0]        rb_pc_o,
    output logic                     recover_done_o
`ifdef SEGRE_HB_STATS_EN
    ,
    output logic [31:0]              stat_retired_o,
    output logic [31:0]              stat_rolled_o,
    output logic [31:0]              stat_full_cyc_o
`endif
);

    typedef enum logic [2:0] {
        E_EMPTY,
        E_BUSY,
        E_BUSY_ST,
        E_DONE,
        E_EXC
    } ent_e;

    typedef enum logic {
        S_NORMAL,
        S_RECOVER
    } fsm_e;

    ent_e               st       [HB_DEPTH];
    logic [REG_W-1:0]   dest_q   [HB_DEPTH];
    logic [DATA_W-1:0]  value_q  [HB_DEPTH];
    logic [ADDR_W-1:0]  pc_q     [HB_DEPTH];

    logic [HB_PTR-1:0]  head, tail, tail_m1;
    logic [HB_PTR:0]    count, count_nxt;
    fsm_e               fsm;
    logic               recover_done_q;
    logic               full, frozen, do_alloc;
    logic [RC_W-1:0]    ret_k;

    assign tail_m1  = tail - 1'b1;
    assign full     = (count == (HB_PTR+1)'(HB_DEPTH));
    // Once the head holds an exception nothing but rollback may touch the buffer.
    assign frozen   = (fsm == S_RECOVER) || (st[head] == E_EXC);
    assign do_alloc = alloc_valid_i && !full && !frozen;

    // Consecutive DONE entries from head, capped at RET_W.
    always_comb begin
        logic              run;
        logic [HB_PTR-1:0] idx;
        ret_k = '0;
        run   = 1'b1;
        idx   = '0;
        for (int i = 0; i < RET_W; i++) begin
            idx = head + HB_PTR'(i);
            if (run && st[idx] == E_DONE) ret_k = ret_k + RC_W'(1);
            else                          run   = 1'b0;
        end
        if (frozen) ret_k = '0;
    end

    assign count_nxt = count + (HB_PTR+1)'(do_alloc) - (HB_PTR+1)'(ret_k);

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            fsm            <= S_NORMAL;
            recover_done_q <= 1'b0;
            for (int i = 0; i < HB_DEPTH; i++) st[i] <= E_EMPTY;
        end else begin
            recover_done_q <= 1'b0;
            if (fsm == S_RECOVER) begin
                st[tail_m1] <= E_EMPTY;
                tail        <= tail_m1;
                count       <= count - 1'b1;
                if (count == (HB_PTR+1)'(1)) begin
                    fsm            <= S_NORMAL;
                    recover_done_q <= 1'b1;
                end
            end else if (st[head] == E_EXC) begin
                fsm <= S_RECOVER;
            end else begin
                for (int i = 0; i < RET_W; i++)
                    if (RC_W'(i) < ret_k) st[head + HB_PTR'(i)] <= E_EMPTY;
                // Only BUSY entries react; the tail slot being allocated is EMPTY here.
                for (int k = 0; k < N_CMPL; k++)
                    if (cmpl_valid_i[k] &&
                        (st[cmpl_id_i[k*HB_PTR +: HB_PTR]] == E_BUSY ||
                         st[cmpl_id_i[k*HB_PTR +: HB_PTR]] == E_BUSY_ST))
                        st[cmpl_id_i[k*HB_PTR +: HB_PTR]] <= E_DONE;
                // Written after completions so the exception wins on the same id.
                if (exc_valid_i && (st[exc_id_i] == E_BUSY || st[exc_id_i] == E_BUSY_ST))
                    st[exc_id_i] <= E_EXC;
                if (do_alloc) begin
                    st[tail] <= alloc_store_i ? E_BUSY_ST : E_BUSY;
                    tail     <= tail + 1'b1;
                end
                head  <= head + HB_PTR'(ret_k);
                count <= count_nxt;
            end
        end
    end

    // Payload needs no reset: it is only observed through non-EMPTY entries.
    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            dest_q[tail]  <= alloc_dest_reg_i;
            value_q[tail] <= alloc_value_i;
            pc_q[tail]    <= alloc_pc_i;
        end
    end

    assign alloc_id_o     = tail;
    assign full_o         = full;
    assign empty_o        = (count == '0);
    assign count_o        = count;
    assign store_perm_o   = (st[head] == E_BUSY_ST) && (fsm == S_NORMAL);
    assign retire_cnt_o   = ret_k;
    assign recovering_o   = (fsm == S_RECOVER);
    assign rb_valid_o     = (fsm == S_RECOVER);
    assign rb_dest_reg_o  = dest_q[tail_m1];
    assign rb_value_o     = value_q[tail_m1];
    assign rb_pc_o        = pc_q[tail_m1];
    assign recover_done_o = recover_done_q;

`ifdef SEGRE_HB_STATS_EN
    logic [32:0] ret_sum, rol_sum, full_sum;
    assign ret_sum  = {1'b0, stat_retired_o}  + 33'(ret_k);
    assign rol_sum  = {1'b0, stat_rolled_o}   + 33'(fsm == S_RECOVER);
    assign full_sum = {1'b0, stat_full_cyc_o} + 33'(full);

    // Saturating counters: the carry-out selects all-ones.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            stat_retired_o  <= '0;
            stat_rolled_o   <= '0;
            stat_full_cyc_o <= '0;
        end else begin
            stat_retired_o  <= ret_sum[32]  ? '1 : ret_sum[31:0];
            stat_rolled_o   <= rol_sum[32]  ? '1 : rol_sum[31:0];
            stat_full_cyc_o <= full_sum[32] ? '1 : full_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_segre_history_buffer.sv
// Directed bench for segre_history_buffer (default parameters, DEPTH=8, RET_W=2, 4 completion ports).
module tb_segre_history_buffer;

    localparam int P = 3;

    logic          clk = 1'b0;
    logic          rsn;
    logic          alloc_valid, alloc_store;
    logic [4:0]    alloc_dest;
    logic [31:0]   alloc_value, alloc_pc;
    logic [P-1:0]  alloc_id;
    logic          full, empty;
    logic [P:0]    count;
    logic [3:0]    cmpl_valid;
    logic [4*P-1:0] cmpl_id;
    logic          exc_valid;
    logic [P-1:0]  exc_id;
    logic          store_perm;
    logic [1:0]    retire_cnt;
    logic          recovering, rb_valid;
    logic [4:0]    rb_dest;
    logic [31:0]   rb_value, rb_pc;
    logic          recover_done;

    int checks = 0;
    int failures = 0;

    segre_history_buffer dut (
        .clk_i(clk), .rsn_i(rsn),
        .alloc_valid_i(alloc_valid), .alloc_store_i(alloc_store),
        .alloc_dest_reg_i(alloc_dest), .alloc_value_i(alloc_value), .alloc_pc_i(alloc_pc),
        .alloc_id_o(alloc_id), .full_o(full), .empty_o(empty), .count_o(count),
        .cmpl_valid_i(cmpl_valid), .cmpl_id_i(cmpl_id),
        .exc_valid_i(exc_valid), .exc_id_i(exc_id),
        .store_perm_o(store_perm), .retire_cnt_o(retire_cnt), .recovering_o(recovering),
        .rb_valid_o(rb_valid), .rb_dest_reg_o(rb_dest), .rb_value_o(rb_value), .rb_pc_o(rb_pc),
        .recover_done_o(recover_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_store = 0; cmpl_valid = '0; exc_valid = 0;
    endtask

    task automatic set_cmpl(input int port, input int id);
        cmpl_valid[port] = 1'b1;
        cmpl_id[port*P +: P] = P'(id);
    endtask

    task automatic do_reset();
        idle();
        rsn = 0;
        tick(); tick();
        rsn = 1;
    endtask

    task automatic alloc_n(input int n, input int pc_base);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1; alloc_store = 0;
            alloc_dest  = 5'(alloc_id + 1);
            alloc_value = 32'(100 + alloc_id);
            alloc_pc    = 32'(pc_base + 4 * alloc_id);
            tick();
        end
        alloc_valid = 0;
    endtask

    initial begin
        alloc_dest = '0; alloc_value = '0; alloc_pc = '0; cmpl_id = '0; exc_id = '0;
        do_reset();
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_sperm", 64'(store_perm), 0);
        chk("rst_rbv", 64'(rb_valid), 0);
        chk("rst_done", 64'(recover_done), 0);
        chk("rst_ret", 64'(retire_cnt), 0);
        chk("rst_id", 64'(alloc_id), 0);

        // Fill: ids 0..7, then a dropped 9th alloc
        for (int i = 0; i < 8; i++) begin
            chk("fill_id", 64'(alloc_id), 64'(i));
            alloc_valid = 1; alloc_pc = 32'(4 * i); alloc_dest = 5'(i); alloc_value = 32'(i);
            tick();
        end
        chk("full_after8", 64'(full), 1);
        chk("cnt_after8", 64'(count), 8);
        tick();
        alloc_valid = 0;
        chk("drop9_cnt", 64'(count), 8);
        chk("drop9_tail", 64'(alloc_id), 0);

        // Out-of-order completion, RET_W cap
        set_cmpl(0, 2); set_cmpl(1, 1); set_cmpl(2, 0);
        tick(); idle();
        chk("ret_2", 64'(retire_cnt), 2);
        tick();
        chk("ret_1", 64'(retire_cnt), 1);
        chk("cnt_6", 64'(count), 6);
        tick();
        chk("ret_0", 64'(retire_cnt), 0);
        chk("cnt_5", 64'(count), 5);
        chk("notfull", 64'(full), 0);
        set_cmpl(0, 3); set_cmpl(1, 4); set_cmpl(2, 5); set_cmpl(3, 6);
        tick(); idle();
        chk("ret_a", 64'(retire_cnt), 2);
        tick();
        chk("ret_b", 64'(retire_cnt), 2);
        chk("cnt_3", 64'(count), 3);
        set_cmpl(0, 7); set_cmpl(1, 7);
        tick(); idle();
        chk("ret_last", 64'(retire_cnt), 1);
        chk("cnt_1", 64'(count), 1);
        tick();
        chk("drain_empty", 64'(empty), 1);

        // Store permission at head
        chk("st_id", 64'(alloc_id), 0);
        alloc_valid = 1; alloc_store = 1;
        tick(); idle();
        chk("st_perm1", 64'(store_perm), 1);
        chk("st_noret", 64'(retire_cnt), 0);
        set_cmpl(0, 0);
        tick(); idle();
        chk("st_perm0", 64'(store_perm), 0);
        chk("st_ret", 64'(retire_cnt), 1);
        tick();
        chk("st_empty", 64'(empty), 1);

        // Rollback of ids 0..4, allocs during recovery dropped
        do_reset();
        alloc_n(5, 0);
        exc_valid = 1; exc_id = 0;
        tick(); idle();
        chk("exc_norec", 64'(recovering), 0);
        alloc_valid = 1;
        tick();
        for (int j = 0; j < 5; j++) begin
            chk("rb_rec", 64'(recovering), 1);
            chk("rb_v", 64'(rb_valid), 1);
            chk("rb_pc", 64'(rb_pc), 64'(4 * (4 - j)));
            chk("rb_dest", 64'(rb_dest), 64'(5 - j));
            chk("rb_val", 64'(rb_value), 64'(104 - j));
            chk("rb_cnt", 64'(count), 64'(5 - j));
            if (j == 4) alloc_valid = 0;
            tick();
        end
        chk("rb_done", 64'(recover_done), 1);
        chk("rb_empty", 64'(empty), 1);
        chk("rb_vend", 64'(rb_valid), 0);
        tick();
        chk("rb_done_pulse", 64'(recover_done), 0);

        // Exception beats completion on id 3; tail=0 rollback wraps to entry 7; reset mid-rollback
        alloc_n(8, 256);
        chk("w_full", 64'(full), 1);
        set_cmpl(0, 0); set_cmpl(1, 1); set_cmpl(2, 2); set_cmpl(3, 3);
        exc_valid = 1; exc_id = 3;
        tick(); idle();
        chk("w_ret2", 64'(retire_cnt), 2);
        tick();
        chk("w_ret1", 64'(retire_cnt), 1);
        tick();
        chk("w_ret_exc", 64'(retire_cnt), 0);
        chk("w_cnt5", 64'(count), 5);
        tick();
        chk("w_rec", 64'(recovering), 1);
        chk("w_pc7", 64'(rb_pc), 256 + 28);
        tick();
        chk("w_pc6", 64'(rb_pc), 256 + 24);
        chk("w_cnt4", 64'(count), 4);
        rsn = 0;
        tick();
        rsn = 1;
        chk("ab_empty", 64'(empty), 1);
        chk("ab_rbv", 64'(rb_valid), 0);
        chk("ab_done", 64'(recover_done), 0);
        chk("ab_rec", 64'(recovering), 0);
        tick();
        chk("ab_done2", 64'(recover_done), 0);
        chk("ab_rbv2", 64'(rb_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
